// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types, default widths and width helpers for the APB arbiter
package apb_arb_pkg;

  // Downstream bus phase; the arbiter owns the slave only outside IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  // Default configuration of the arbiter.
  localparam int NUM_MASTERS_DEF    = 2;
  localparam int ADDR_WIDTH_DEF     = 13;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  // Ceiling log2 that never returns zero, so it can size a vector directly.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  // Widths for the default configuration: grant index and wait counter.
  localparam int GRANT_W = clog2_min1(NUM_MASTERS_DEF);
  localparam int TO_W    = clog2_min1(TIMEOUT_CYCLES_DEF + 1);

endpackage

// File: rtl/apb_rr_picker.sv
// rtl/apb_rr_picker.sv - combinational round-robin priority encoder
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int GW          = clog2_min1(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GW-1:0]          last_grant,
  output logic                   valid,
  output logic [GW-1:0]          idx
);

  int cand;

  // Scan from the port after the last winner, wrapping; the first requester found wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = (int'(last_grant) + k) % NUM_MASTERS;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - round-robin sharing of one APB3 slave between several APB masters
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = NUM_MASTERS_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                              PCLK,
  input  logic                              PRESET,
  input  logic [NUM_MASTERS-1:0]            s_psel,
  input  logic [NUM_MASTERS-1:0]            s_penable,
  input  logic [NUM_MASTERS-1:0]            s_pwrite,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_paddr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_pwdata,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_prdata,
  output logic [NUM_MASTERS-1:0]            s_pready,
  output logic [NUM_MASTERS-1:0]            s_pslverr,
  output logic                              m_psel,
  output logic                              m_penable,
  output logic                              m_pwrite,
  output logic [ADDR_WIDTH-1:0]             m_paddr,
  output logic [DATA_WIDTH-1:0]             m_pwdata,
  input  logic [DATA_WIDTH-1:0]             m_prdata,
  input  logic                              m_pready,
  input  logic                              m_pslverr
);

  localparam int GW = clog2_min1(NUM_MASTERS);
  localparam int TW = clog2_min1(TIMEOUT_CYCLES + 1);

  arb_state_e    state;
  logic [GW-1:0] grant;
  logic [GW-1:0] last_grant;
  logic [TW-1:0] wait_cnt;

  logic          pick_valid;
  logic [GW-1:0] pick_idx;

  logic          done_ok;
  logic          timed_out;
  logic          finish;
  logic          deliver;

  apb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .GW          (GW)
  ) u_picker (
    .req        (s_psel),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  // Decide whether the current ACCESS cycle ends the transfer, by slave handshake or by timeout.
  // The timeout fires in the last allowed ACCESS cycle, so the slave sees at most
  // TIMEOUT_CYCLES cycles of PENABLE. A master that already dropped PSEL gets nothing back.
  always_comb begin
    done_ok   = (state == ACCESS) && m_pready;
    timed_out = (TIMEOUT_CYCLES > 0) && (state == ACCESS) && !m_pready &&
                ((int'(wait_cnt) + 1) >= TIMEOUT_CYCLES);
    finish    = done_ok || timed_out;
    deliver   = finish && s_psel[grant] && s_penable[grant];
  end

  // Route the completion to the granted port only; every other port sees zeros.
  always_comb begin
    s_pready  = '0;
    s_pslverr = '0;
    s_prdata  = '0;
    if (deliver) begin
      s_pready[grant]  = 1'b1;
      s_pslverr[grant] = timed_out ? 1'b1 : m_pslverr;
      s_prdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH] = timed_out ? '0 : m_prdata;
    end
  end

  // Downstream phase sequencing with registered bus outputs and round-robin bookkeeping.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
      wait_cnt   <= '0;
      m_psel     <= 1'b0;
      m_penable  <= 1'b0;
      m_pwrite   <= 1'b0;
      m_paddr    <= '0;
      m_pwdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant    <= pick_idx;
            m_pwrite <= s_pwrite[pick_idx];
            m_paddr  <= s_paddr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            m_pwdata <= s_pwdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            m_psel   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt  <= '0;
          m_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (finish) begin
            // The winner rotates to the back of the queue even when the slave timed out.
            m_psel     <= 1'b0;
            m_penable  <= 1'b0;
            last_grant <= grant;
            wait_cnt   <= '0;
            state      <= IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          m_psel    <= 1'b0;
          m_penable <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - randomized and directed self-checking bench for apb_arbiter
module tb_apb_arbiter;

  localparam int N  = 2;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    s_psel, s_penable, s_pwrite;
  logic [N*AW-1:0] s_paddr;
  logic [N*DW-1:0] s_pwdata, s_prdata;
  logic [N-1:0]    s_pready, s_pslverr;
  logic            m_psel, m_penable, m_pwrite;
  logic [AW-1:0]   m_paddr;
  logic [DW-1:0]   m_pwdata, m_prdata;
  logic            m_pready, m_pslverr;

  always #5 PCLK = ~PCLK;

  apb_arbiter #(
    .NUM_MASTERS    (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_pwrite  (s_pwrite),
    .s_paddr   (s_paddr),
    .s_pwdata  (s_pwdata),
    .s_prdata  (s_prdata),
    .s_pready  (s_pready),
    .s_pslverr (s_pslverr),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Upstream master models
  int            mst_st [N];   // 0 idle, 1 setup, 2 access
  int            pend   [N];
  logic          mw     [N];
  logic [AW-1:0] ma     [N];
  logic [DW-1:0] md     [N];
  logic          nx_w   [N];
  logic [AW-1:0] nx_a   [N];
  logic [DW-1:0] nx_d   [N];
  int            t_start[N];
  int            waited [N];
  int            last_lat[N];
  logic          last_err[N];
  logic [DW-1:0] last_rd [N];

  // Slave model
  logic [DW-1:0] mem [16];
  int            sl_wait;
  logic          sl_err;
  int            force_wait = -1;
  int            force_err  = -1;
  bit            rand_mode  = 0;

  // Transfer-level reference state
  int           last_served;
  int           cur;
  int           acc_cnt;
  int           last_pen;
  int           cyc = 0;
  bit           done_prev, setup_prev, prev_idle;
  logic [N-1:0] req_prev;
  int           order_q[$];

  function automatic int rr_expect(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b = m_psel;
    for (int i = 0; i < N; i++) if (pend[i] != 0 || mst_st[i] != 0) b = 1;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mst_st[i] = 0; pend[i] = 0; waited[i] = 0;
    end
    s_psel = '0; s_penable = '0;
    last_served = N - 1; cur = -1; acc_cnt = 0;
    done_prev = 0; setup_prev = 0; prev_idle = 1; req_prev = '0;
  endtask

  task automatic step();
    logic [N-1:0]    er, ee;
    logic [N*DW-1:0] ed;
    bit              fin, tout;
    int              e;
    @(posedge PCLK); #1;
    cyc++;
    // masters
    for (int i = 0; i < N; i++) begin
      if (mst_st[i] == 0) begin
        if (pend[i] > 0) begin
          if (rand_mode) begin
            nx_w[i] = ($urandom_range(0, 1) == 1);
            nx_a[i] = AW'($urandom_range(0, 15) * 4);
            nx_d[i] = $urandom;
          end
          mw[i] = nx_w[i]; ma[i] = nx_a[i]; md[i] = nx_d[i];
          pend[i]--; mst_st[i] = 1; t_start[i] = cyc;
          s_psel[i] = 1'b1; s_penable[i] = 1'b0; s_pwrite[i] = mw[i];
          s_paddr[i*AW +: AW] = ma[i]; s_pwdata[i*DW +: DW] = md[i];
        end else begin
          s_psel[i] = 1'b0; s_penable[i] = 1'b0;
        end
      end else if (mst_st[i] == 1) begin
        s_penable[i] = 1'b1; mst_st[i] = 2;
      end
    end
    // downstream phase rules
    if (done_prev)  check("bubble_after_done", m_psel, 1'b0);
    if (setup_prev) check("access_after_setup", {m_psel, m_penable}, 2'b11);
    if (prev_idle && |req_prev) check("pick_taken", {m_psel, m_penable}, 2'b10);
    // slave
    if (m_psel && !m_penable) begin
      e = rr_expect(req_prev, last_served);
      check("grant_valid", e >= 0, 1'b1);
      if (e >= 0) begin
        cur = e;
        check("m_paddr", m_paddr, ma[e]);
        check("m_pwdata", m_pwdata, md[e]);
        check("m_pwrite", m_pwrite, mw[e]);
      end
      sl_wait = (force_wait >= 0) ? force_wait :
                (($urandom_range(0, 15) == 0) ? 40 : $urandom_range(0, 3));
      sl_err  = (force_err >= 0) ? (force_err != 0) : ($urandom_range(0, 7) == 0);
      acc_cnt = 0;
      m_pready = 1'b0; m_prdata = $urandom; m_pslverr = ($urandom_range(0, 1) == 1);
    end else if (m_psel && m_penable) begin
      acc_cnt++;
      if (cur >= 0) check("m_paddr_hold", m_paddr, ma[cur]);
      if (sl_wait == 0) begin
        m_pready = 1'b1; m_pslverr = sl_err;
        m_prdata = m_pwrite ? $urandom : mem[m_paddr[5:2]];
      end else begin
        sl_wait--;
        m_pready = 1'b0; m_prdata = $urandom; m_pslverr = ($urandom_range(0, 1) == 1);
      end
    end else begin
      m_pready = ($urandom_range(0, 1) == 1); m_prdata = $urandom;
      m_pslverr = ($urandom_range(0, 1) == 1);
    end
    #2;
    // upstream response expectations
    er = '0; ee = '0; ed = '0; fin = 0; tout = 0;
    if (m_psel && m_penable && m_pready) fin = 1;
    else if (m_psel && m_penable && acc_cnt == TO) begin fin = 1; tout = 1; end
    if (fin && cur >= 0 && mst_st[cur] == 2) begin
      er[cur] = 1'b1;
      ee[cur] = tout ? 1'b1 : m_pslverr;
      ed[cur*DW +: DW] = tout ? '0 : m_prdata;
    end
    check("s_pready", s_pready, er);
    check("s_pslverr", s_pslverr, ee);
    check("s_prdata", s_prdata, ed);
    if (fin && cur >= 0) begin
      if (!tout && m_pwrite && !m_pslverr) mem[m_paddr[5:2]] = m_pwdata;
      check("fairness", waited[cur] <= N - 1, 1'b1);
      waited[cur] = 0;
      for (int j = 0; j < N; j++) if (j != cur && mst_st[j] != 0) waited[j]++;
      last_served   = cur;
      order_q.push_back(cur);
      last_lat[cur] = cyc - t_start[cur];
      last_err[cur] = s_pslverr[cur];
      last_rd[cur]  = s_prdata[cur*DW +: DW];
      last_pen      = acc_cnt;
      mst_st[cur]   = 0;
      cur           = -1;
    end
    done_prev  = fin;
    setup_prev = m_psel && !m_penable;
    prev_idle  = !m_psel;
    req_prev   = s_psel;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check("drain_done", busy(), 1'b0);
  endtask

  task automatic queue_op(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    nx_w[m] = w; nx_a[m] = a; nx_d[m] = d; pend[m] = 1;
  endtask

  initial begin
    int exp2[4] = '{0, 1, 0, 1};
    int n;
    for (int i = 0; i < 16; i++) mem[i] = 32'h01010101 * i;
    s_pwrite = '0; s_paddr = '0; s_pwdata = '0;
    m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
    model_reset();
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_m_psel", m_psel, 1'b0);
    check("rst_m_penable", m_penable, 1'b0);
    check("rst_m_pwrite", m_pwrite, 1'b0);
    check("rst_m_paddr", m_paddr, '0);
    check("rst_m_pwdata", m_pwdata, '0);
    check("rst_s_pready", s_pready, '0);
    check("rst_s_pslverr", s_pslverr, '0);
    check("rst_s_prdata", s_prdata, '0);
    PRESET = 1'b0;

    // simultaneous requests after reset alternate starting with master 0
    force_wait = 0; force_err = 0;
    for (int i = 0; i < N; i++) begin
      nx_w[i] = 1'b0; nx_a[i] = AW'(8 * (i + 1)); nx_d[i] = '0; pend[i] = 2;
    end
    order_q.delete();
    drain(100);
    check("order_size", order_q.size(), 4);
    if (order_q.size() == 4)
      for (int k = 0; k < 4; k++) check($sformatf("order_%0d", k), order_q[k], exp2[k]);

    // zero-wait write then readback on master 0
    queue_op(0, 1'b1, 13'd4, 32'h12345678);
    drain(50);
    check("t1_lat_wr", last_lat[0], 2);
    check("t1_m_paddr", m_paddr, 13'd4);
    check("t1_m_pwdata", m_pwdata, 32'h12345678);
    queue_op(0, 1'b0, 13'd4, 32'h0);
    drain(50);
    check("t1_readback", last_rd[0], 32'h12345678);
    check("t1_lat_rd", last_rd[0] == 32'h12345678 ? last_lat[0] : -1, 2);

    // three wait states on a master 1 read
    queue_op(0, 1'b1, 13'd8, 32'hDEADBEEF);
    drain(50);
    force_wait = 3;
    queue_op(1, 1'b0, 13'd8, 32'h0);
    drain(50);
    check("t3_penable_cycles", last_pen, 4);
    check("t3_rdata", last_rd[1], 32'hDEADBEEF);
    check("t3_lat", last_lat[1], 5);

    // slave never ready: timeout then normal service
    force_wait = 100;
    queue_op(0, 1'b0, 13'd12, 32'h0);
    drain(100);
    check("t4_err", last_err[0], 1'b1);
    check("t4_rdata", last_rd[0], 32'h0);
    check("t4_access_cycles", last_pen, TO);
    force_wait = 0;
    queue_op(1, 1'b0, 13'd4, 32'h0);
    drain(50);
    check("t4_next_err", last_err[1], 1'b0);
    check("t4_next_lat", last_lat[1], 2);
    check("t4_next_rdata", last_rd[1], 32'h12345678);

    // slave error on completion
    force_wait = 1; force_err = 1;
    queue_op(0, 1'b1, 13'd16, 32'hCAFEF00D);
    drain(50);
    check("t5_err", last_err[0], 1'b1);
    force_err = 0;

    // reset in the middle of ACCESS
    force_wait = 10;
    queue_op(1, 1'b0, 13'd20, 32'h0);
    n = 0;
    while (!m_penable && n < 20) begin
      step();
      n++;
    end
    check("t6_reached_access", m_penable, 1'b1);
    step();
    @(posedge PCLK); #3;
    PRESET = 1'b1;
    #1;
    check("t6_m_psel", m_psel, 1'b0);
    check("t6_m_penable", m_penable, 1'b0);
    check("t6_s_pready", s_pready, '0);
    model_reset();
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    force_wait = 0;
    queue_op(1, 1'b0, 13'd24, 32'h0);
    queue_op(0, 1'b0, 13'd28, 32'h0);
    order_q.delete();
    drain(50);
    check("t6_order_size", order_q.size(), 2);
    if (order_q.size() == 2) check("t6_first", order_q[0], 0);

    // randomized traffic with random wait states, errors and occasional timeouts
    rand_mode = 1; force_wait = -1; force_err = -1;
    repeat (1500) begin
      for (int i = 0; i < N; i++)
        if (pend[i] == 0 && $urandom_range(0, 2) == 0) pend[i] = 1;
      step();
    end
    for (int i = 0; i < N; i++) pend[i] = 0;
    drain(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
